// File: rtl/text_seg_pkg.sv
// Shared types and width helpers for the text-line profiler.
// The ink field of seg_t exists only when TEXT_LINE_INK_EN is defined.
package text_seg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        IN_LINE,
        GAP
    } state_t;

    // Segment fields are sized for the largest supported image; users slice down.
    localparam int SEG_RW = 16;
    localparam int SEG_IW = 32;

    typedef struct packed {
        logic [SEG_RW-1:0] top;
        logic [SEG_RW-1:0] bottom;
`ifdef TEXT_LINE_INK_EN
        logic [SEG_IW-1:0] ink;
`endif
    } seg_t;

    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    function automatic int rw_f(input int img_h);
        return clog2_min1(img_h);
    endfunction

    function automatic int cw_f(input int img_w);
        return clog2_min1(img_w);
    endfunction

    function automatic int iw_f(input int img_w, input int img_h);
        return clog2_min1(img_w * img_h + 1);
    endfunction

endpackage

// File: rtl/line_seg_fifo.sv
// Synchronous segment FIFO with full/empty flags and a registered head output.
// DEPTH must be a power of two (>= 2).
module line_seg_fifo
    import text_seg_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  seg_t i_data,
    input  logic i_pop,
    output seg_t o_data,
    output logic o_full,
    output logic o_empty
);

    localparam int PW = clog2_min1(DEPTH);

    seg_t          r_mem [DEPTH];
    seg_t          r_out;
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [PW:0]   r_count;
    logic [PW-1:0] w_rd_n;
    logic [PW:0]   w_count_n;
    logic          w_do_push;
    logic          w_do_pop;
    logic          w_bypass;

    assign o_full    = (r_count == (PW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign w_rd_n    = r_rd + PW'(w_do_pop);
    assign w_count_n = r_count + (PW+1)'(w_do_push) - (PW+1)'(w_do_pop);
    // The incoming entry becomes the head when nothing older survives this cycle.
    assign w_bypass  = w_do_push && (r_count == (PW+1)'(w_do_pop));
    assign o_data    = r_out;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_out   <= '0;
        end else begin
            r_wr    <= r_wr + PW'(w_do_push);
            r_rd    <= w_rd_n;
            r_count <= w_count_n;
            r_out   <= w_bypass ? i_data : r_mem[w_rd_n];
        end
    end

endmodule

// File: rtl/text_line_profiler.sv
// Horizontal projection of a binarized frame into text-line segments.
// Define TEXT_LINE_INK_EN to accumulate per-segment ink; otherwise m_ink is 0.
module text_line_profiler
    import text_seg_pkg::*;
#(
    parameter  int IMG_W      = 64,
    parameter  int IMG_H      = 64,
    parameter  int MIN_INK    = 1,
    parameter  int MIN_GAP    = 2,
    parameter  int FIFO_DEPTH = 4,
    localparam int RW         = rw_f(IMG_H),
    localparam int CW         = cw_f(IMG_W),
    localparam int IW         = iw_f(IMG_W, IMG_H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [7:0]    s_pix,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [RW-1:0] m_top,
    output logic [RW-1:0] m_bottom,
    output logic [IW-1:0] m_ink,
    output logic          frame_done
);

    localparam int AW = clog2_min1(IMG_W + 1);
    localparam int GW = clog2_min1(MIN_GAP + 1);

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [AW-1:0] r_row_ink;
    state_t        r_state, w_state_n;
    logic [GW-1:0] r_gap, w_gap_n;
    logic [RW-1:0] r_top, r_bot, w_top_n, w_bot_n;
    logic          r_frame_done;
`ifdef TEXT_LINE_INK_EN
    logic [IW-1:0] r_ink, w_ink_n, w_row_sum_iw;
`endif

    logic          w_acc, w_fg, w_row_end, w_frame_end, w_text, w_push;
    logic          w_full, w_empty;
    logic [AW-1:0] w_row_sum;
    seg_t          w_push_data, w_head;

    assign w_acc       = s_valid && s_ready;
    assign w_fg        = (s_pix == 8'd0);
    assign w_row_end   = w_acc && (r_col == CW'(IMG_W - 1));
    assign w_frame_end = w_row_end && (r_row == RW'(IMG_H - 1));
    assign w_row_sum   = r_row_ink + AW'(w_fg);
    assign w_text      = (w_row_sum >= AW'(MIN_INK));
`ifdef TEXT_LINE_INK_EN
    assign w_row_sum_iw = IW'(w_row_sum);
`endif

    // Line tracker: advances only on row-end beats, at most one emit per row.
    always_comb begin
        w_state_n = r_state;
        w_gap_n   = r_gap;
        w_top_n   = r_top;
        w_bot_n   = r_bot;
`ifdef TEXT_LINE_INK_EN
        w_ink_n   = r_ink;
`endif
        w_push    = 1'b0;
        if (w_row_end) begin
            unique case (r_state)
                IDLE: begin
                    if (w_text) begin
                        w_state_n = IN_LINE;
                        w_top_n   = r_row;
                        w_bot_n   = r_row;
`ifdef TEXT_LINE_INK_EN
                        w_ink_n   = w_row_sum_iw;
`endif
                    end
                end
                IN_LINE: begin
                    if (w_text) begin
                        w_bot_n = r_row;
`ifdef TEXT_LINE_INK_EN
                        w_ink_n = r_ink + w_row_sum_iw;
`endif
                    end else if (MIN_GAP == 1) begin
                        w_push    = 1'b1;
                        w_state_n = IDLE;
                    end else begin
                        w_state_n = GAP;
                        w_gap_n   = GW'(1);
                    end
                end
                GAP: begin
                    if (w_text) begin
                        w_state_n = IN_LINE;
                        w_bot_n   = r_row;
`ifdef TEXT_LINE_INK_EN
                        w_ink_n   = r_ink + w_row_sum_iw;
`endif
                    end else begin
                        w_gap_n = r_gap + GW'(1);
                        if (w_gap_n >= GW'(MIN_GAP)) begin
                            w_push    = 1'b1;
                            w_state_n = IDLE;
                        end
                    end
                end
                default: w_state_n = IDLE;
            endcase
            if (w_frame_end && (w_state_n != IDLE)) begin
                w_push    = 1'b1;
                w_state_n = IDLE;
            end
        end
    end

    always_comb begin
        w_push_data        = '0;
        w_push_data.top    = SEG_RW'(w_top_n);
        w_push_data.bottom = SEG_RW'(w_bot_n);
`ifdef TEXT_LINE_INK_EN
        w_push_data.ink    = SEG_IW'(w_ink_n);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col        <= '0;
            r_row        <= '0;
            r_row_ink    <= '0;
            r_state      <= IDLE;
            r_gap        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_frame_end;
            r_state      <= w_state_n;
            r_gap        <= w_gap_n;
            if (w_acc) begin
                if (r_col == CW'(IMG_W - 1)) begin
                    r_col     <= '0;
                    r_row     <= (r_row == RW'(IMG_H - 1)) ? '0 : r_row + RW'(1);
                    r_row_ink <= '0;
                end else begin
                    r_col     <= r_col + CW'(1);
                    r_row_ink <= w_row_sum;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        r_top <= w_top_n;
        r_bot <= w_bot_n;
`ifdef TEXT_LINE_INK_EN
        r_ink <= w_ink_n;
`endif
    end

    line_seg_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (m_ready),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign s_ready    = !w_full;
    assign m_valid    = !w_empty;
    assign m_top      = w_head.top[RW-1:0];
    assign m_bottom   = w_head.bottom[RW-1:0];
    assign frame_done = r_frame_done;

    logic w_unused_hi;
`ifdef TEXT_LINE_INK_EN
    assign m_ink       = w_head.ink[IW-1:0];
    assign w_unused_hi = ^{w_head.top[SEG_RW-1:RW], w_head.bottom[SEG_RW-1:RW],
                           w_head.ink[SEG_IW-1:IW]};
`else
    assign m_ink       = '0;
    assign w_unused_hi = ^{w_head.top[SEG_RW-1:RW], w_head.bottom[SEG_RW-1:RW]};
`endif

endmodule

// File: doc/text_line_profiler.md
# text_line_profiler

Streaming horizontal-projection stage that consumes the binarized image from the adaptive-threshold stage, one 8-bit pixel per accepted beat in raster order. It counts foreground (text) pixels per row and groups consecutive text rows into text-line segments. Each segment (top row, bottom row, ink count) is pushed through a small output FIFO to the downstream character-segmentation logic. A pixel byte of 0 is foreground; any nonzero byte is background.

## Interface
- IMG_W, 64: pixels per row.
- IMG_H, 64: rows per frame.
- MIN_INK, 1: minimum foreground pixels for a row to count as a text row.
- MIN_GAP, 2: consecutive blank rows that close an open line (≥1).
- FIFO_DEPTH, 4: output segment FIFO entries (power of 2).
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- s_valid  in  1  pixel valid.
- s_ready  out  1  pixel accepted when s_valid && s_ready.
- s_pix  in  8  binarized pixel (0 = foreground).
- m_valid  out  1  segment available.
- m_ready  in  1  consumer pops on m_valid && m_ready.
- m_top  out  RW  first text row of segment.
- m_bottom  out  RW  last text row of segment.
- m_ink  out  IW  total foreground pixels in rows top..bottom.
- frame_done  out  1  one-cycle pulse after frame end.

Width rules: RW = $clog2(IMG_H), CW = $clog2(IMG_W), IW = $clog2(IMG_W*IMG_H+1).

## Operation
- Column counter col (CW bits) and row counter row (RW bits) advance on each accept. col wraps at IMG_W-1 and increments row. row wraps at IMG_H-1, which is the end of the frame.
- Row accumulator row_ink ($clog2(IMG_W+1) bits) adds 1 per foreground beat. It clears after each row end.
- Row end is the accept of col==IMG_W-1. The row is a text row when row_ink + fg_this_beat ≥ MIN_INK.
- FSM states (updated only at row end):
  - IDLE, text row: go to IN_LINE; top = bottom = row; ink = row sum.
  - IDLE, blank row: stay in IDLE.
  - IN_LINE, text row: bottom = row; ink += row sum.
  - IN_LINE, blank row: go to GAP; gap = 1. If MIN_GAP==1, emit and go to IDLE instead.
  - GAP, text row: go to IN_LINE; bottom = row; ink += row sum; gap rows merge into the line.
  - GAP, blank row: gap++. If gap reaches MIN_GAP, emit and go to IDLE.
- Frame end: if the state is IN_LINE or GAP after the row update, emit (bottom = last text row). The FSM then returns to IDLE and counters clear. Only one emit can occur per row end.
- Emit pushes {top, bottom, ink} into the FIFO.
- s_ready = !fifo_full. The stage stalls whole beats and never drops a segment, so overflow is impossible.
- Simultaneous push and pop on a non-full FIFO: both occur and the count is unchanged.
- rst mid-frame: col, row, row_ink, FSM and FIFO clear. Any partial line is discarded. The next accepted pixel is treated as (0,0).

## Timing
- Reset values: s_ready=1, m_valid=0, m_top=0, m_bottom=0, m_ink=0, frame_done=0.
- Segment latency: a segment is pushed at the row-end accept in cycle N. m_valid is high in cycle N+1 when the FIFO was empty.
- frame_done pulses in cycle N+1 after the final pixel's accept, in the same cycle as any frame-end segment appearing on m_valid.
- m_* outputs are stable while m_valid && !m_ready.
- s_ready falls in the cycle after the push that fills the FIFO. It rises in the cycle after a pop.

## Configuration
- TEXT_LINE_INK_EN defined: ink accumulation and the m_ink output are active, and FIFO entries carry ink.
- Undefined: the ink accumulator and the FIFO ink field are removed, and m_ink is tied to 0. Row classification still uses row_ink.

## Structure
- Package text_seg_pkg holds:
  - the FSM state enum (IDLE, IN_LINE, GAP);
  - the segment struct {top, bottom, ink};
  - width helper functions for RW, CW, IW.
- Sub-module line_seg_fifo: a synchronous FIFO of segment structs with full/empty flags and registered outputs.

## Test plan
Base config unless noted: IMG_W=8, IMG_H=8, MIN_INK=1, MIN_GAP=2, FIFO_DEPTH=4, m_ready=1.
- Frame of all 8'hFF -> no m_valid; frame_done pulses 1 cycle after the 64th accept.
- Rows 1–2 each with 3 zero pixels -> one segment top=1, bottom=2, ink=6; m_valid the cycle after the last pixel of row 4.
- Ink on rows 1 and 3 only (1 px each) -> single merged segment top=1, bottom=3, ink=2.
- Ink only on row 7 (2 px) -> segment top=7, bottom=7, ink=2, with m_valid and frame_done in the same cycle.
- MIN_GAP=1, ink on rows 0, 2, 4, 6, m_ready=0 -> 4 segments queued; s_ready=0 after the 4th push; next-frame pixels stall until m_ready=1 pops the first entry (top=0, bottom=0).
- rst asserted after 3 ink pixels of row 1 -> no segment and no frame_done; the next full frame behaves as the row 1–2 case.
